// File: rtl/sd_pkg.sv
// Shared definitions for the sphere-detection datapath: output widths,
// the ED pipeline depth, the candidate-streamer FSM states and QAM grid mapping.
package sd_pkg;

  localparam int ED_W           = 32;
  localparam int NODE_W         = 32;
  localparam int ED_PIPE_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } ed_stream_state_t;

  // Grid value of node idx on one axis of a side x side square QAM grid.
  // quad = 0 gives the in-phase value (column), quad = 1 the quadrature (row).
  // Axis points sit at odd integers centred on zero: -(side-1) .. +(side-1).
  function automatic int node_coord(input int unsigned idx,
                                    input int unsigned side,
                                    input logic        quad);
    int unsigned pos;
    pos = quad ? (idx / side) : (idx % side);
    return 2 * int'(pos) - (int'(side) - 1);
  endfunction

endpackage

// File: rtl/ed_calc.sv
// Two-stage pipelined squared Euclidean distance between a received point and
// one grid node. Stage 1 registers the axis differences, stage 2 registers the
// sum of squares. Shared with the tree-search stage.
module ed_calc
  import sd_pkg::*;
#(
  parameter int COORD_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic                      valid_i,
  input  logic [NODE_W-1:0]         node_i,
  input  logic signed [COORD_W-1:0] rx_re_i,
  input  logic signed [COORD_W-1:0] rx_im_i,
  input  logic signed [COORD_W-1:0] grid_re_i,
  input  logic signed [COORD_W-1:0] grid_im_i,
  output logic                      valid_o,
  output logic [NODE_W-1:0]         node_o,
  output logic [ED_W-1:0]           ed_o
);

  localparam int DIFF_W = COORD_W + 1;
  localparam int SQ_W   = 2 * DIFF_W;
  localparam int SUM_W  = SQ_W + 1;

  logic signed [DIFF_W-1:0] dre_d, dim_d, dre_q, dim_q;
  logic [SQ_W-1:0]          sq_re, sq_im;
  logic [SUM_W-1:0]         sum_d, sum_q;
  logic                     s1_valid_q, s2_valid_q;
  logic [NODE_W-1:0]        s1_node_q, s2_node_q;

  // Differences for stage 1 and sum of squares for stage 2.
  always_comb begin
    // NOTE: every variable here is assigned on every path, so no latch can be
    // inferred; any conditional logic in an always_comb needs a default first.
    dre_d = DIFF_W'(rx_re_i) - DIFF_W'(grid_re_i);
    dim_d = DIFF_W'(rx_im_i) - DIFF_W'(grid_im_i);
    // Sign-extend before multiplying so the product of two negatives is exact.
    sq_re = SQ_W'(dre_q) * SQ_W'(dre_q);
    sq_im = SQ_W'(dim_q) * SQ_W'(dim_q);
    sum_d = SUM_W'(sq_re) + SUM_W'(sq_im);
  end

  // Valid bits: reset and flushable, they alone decide what leaves the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else if (flush_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= valid_i;
      s2_valid_q <= s1_valid_q;
    end
  end

  // Data payload of both stages.
  // NOTE: payload registers carry no reset; they are only observed when the
  // matching valid bit is set, which keeps reset fan-out off the datapath.
  always_ff @(posedge clk) begin
    dre_q     <= dre_d;
    dim_q     <= dim_d;
    s1_node_q <= node_i;
    sum_q     <= sum_d;
    s2_node_q <= s1_node_q;
  end

  assign valid_o = s2_valid_q;
  assign node_o  = s2_node_q;
  assign ed_o    = ED_W'(sum_q);

endmodule

// File: rtl/ed_streamer.sv
// Candidate generator: walks every node of a QAM_SIDE x QAM_SIDE grid for one
// latched received point and streams (node, ED) pairs framed by enable, in the
// format consumed by the two-minimum finder. done marks a completed frame.
module ed_streamer
  import sd_pkg::*;
#(
  parameter int QAM_SIDE = 4,
  parameter int COORD_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  input  logic signed [COORD_W-1:0] rx_i,
  input  logic signed [COORD_W-1:0] rx_q,
  output logic                      enable,
  output logic [NODE_W-1:0]         node_out,
  output logic [ED_W-1:0]           ed_out,
  output logic                      busy,
  output logic                      done
);

  localparam int NUM_NODES = QAM_SIDE * QAM_SIDE;
  localparam int IDX_W     = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);
  // DRAIN counts down from here to zero: the ED pipeline stages plus the
  // output register, so GAP starts exactly when enable drops.
  localparam logic [1:0] DRAIN_LOAD = 2'(ED_PIPE_STAGES);

  ed_stream_state_t          state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [1:0]                drain_q, drain_d;
  logic                      capture, issue, flush;
  logic signed [COORD_W-1:0] rx_re_q, rx_im_q;
  logic signed [COORD_W-1:0] grid_re, grid_im;
  logic                      calc_valid;
  logic [NODE_W-1:0]         calc_node;
  logic [ED_W-1:0]           calc_ed;
  logic                      enable_q, busy_q, done_q;
  logic [NODE_W-1:0]         node_q;
  logic [ED_W-1:0]           ed_q;

  assign grid_re = COORD_W'(node_coord(32'(idx_q), QAM_SIDE, 1'b0));
  assign grid_im = COORD_W'(node_coord(32'(idx_q), QAM_SIDE, 1'b1));

  ed_calc #(
    .COORD_W (COORD_W)
  ) u_ed_calc (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush),
    .valid_i   (issue),
    .node_i    (NODE_W'(idx_q)),
    .rx_re_i   (rx_re_q),
    .rx_im_i   (rx_im_q),
    .grid_re_i (grid_re),
    .grid_im_i (grid_im),
    .valid_o   (calc_valid),
    .node_o    (calc_node),
    .ed_o      (calc_ed)
  );

  // Next-state logic: frame sequencing, index walk, drain count, abort.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    capture = 1'b0;
    issue   = 1'b0;
    flush   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // abort beats a simultaneous start.
        if (start && !abort) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        issue = 1'b1;
        if (idx_q == LAST_IDX) begin
          drain_d = DRAIN_LOAD;
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 2'd0) state_d = ST_GAP;
        else                 drain_d = drain_q - 2'd1;
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      issue   = 1'b0;
      flush   = 1'b1;
    end
  end

  // State, counters, coordinate latch and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      drain_q  <= 2'd0;
      rx_re_q  <= '0;
      rx_im_q  <= '0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      node_q   <= '0;
      ed_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      drain_q  <= drain_d;
      busy_q   <= (state_d != ST_IDLE);
      done_q   <= (state_d == ST_GAP);
      enable_q <= calc_valid && !flush;
      if (capture) begin
        rx_re_q <= rx_i;
        rx_im_q <= rx_q;
      end
      // node/ED hold their last pair while enable is low.
      if (calc_valid && !flush) begin
        node_q <= calc_node;
        ed_q   <= calc_ed;
      end
    end
  end

  assign enable   = enable_q;
  assign node_out = node_q;
  assign ed_out   = ed_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_ed_streamer.sv
// Directed bench for ed_streamer (QAM_SIDE=4, COORD_W=8): table of hand-computed
// (rx, node, ED) vectors plus sequences for back-to-back, abort and reset.
module tb_ed_streamer;

  localparam int SIDE = 4;
  localparam int CW   = 8;
  localparam int NN   = SIDE * SIDE;

  typedef struct {
    int ri;
    int rq;
    int node;
    int ed;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic                 abort;
  logic signed [CW-1:0] rx_i;
  logic signed [CW-1:0] rx_q;
  logic                 enable;
  logic [31:0]          node_out;
  logic [31:0]          ed_out;
  logic                 busy;
  logic                 done;

  int   tests = 0;
  int   fails = 0;
  int   cap_ed [NN];
  vec_t vecs [14];

  always #5 clk = ~clk;

  ed_streamer #(
    .QAM_SIDE (SIDE),
    .COORD_W  (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .rx_i     (rx_i),
    .rx_q     (rx_q),
    .enable   (enable),
    .node_out (node_out),
    .ed_out   (ed_out),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int ed_model(input int ri, input int rq, input int n);
    int gi, gq;
    gi = 2 * (n % SIDE) - (SIDE - 1);
    gq = 2 * (n / SIDE) - (SIDE - 1);
    return (ri - gi) * (ri - gi) + (rq - gq) * (rq - gq);
  endfunction

  // Present rx with start for one edge (or keep start high if hold), then
  // return at the falling edge after the sampling edge T.
  task automatic launch(input int ri, input int rq, input bit hold);
    @(negedge clk);
    rx_i  = CW'(ri);
    rx_q  = CW'(rq);
    start = 1'b1;
    @(negedge clk);
    if (!hold) begin
      start = 1'b0;
      rx_i  = ~rx_i;
      rx_q  = ~rx_q;
    end
    check("busy_after_start", busy, 1);
  endtask

  // Called at the falling edge after T: checks latency, the full frame and the
  // done/busy handshake; returns at the falling edge where busy has dropped.
  task automatic collect(input int ri, input int rq);
    int lat;
    int cnt;
    lat = 0;
    cnt = 0;
    while (!enable && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check("start_to_enable_latency", lat, 3);
    while (enable && cnt < 40) begin
      check("node_order", node_out, cnt);
      check("ed_frame", ed_out, ed_model(ri, rq, cnt));
      if (cnt < NN) cap_ed[cnt] = ed_out;
      @(negedge clk);
      cnt++;
    end
    check("enable_cycles", cnt, NN);
    check("done_on_first_low", done, 1);
    check("busy_during_done", busy, 1);
    check("node_hold_after_frame", node_out, NN - 1);
    @(negedge clk);
    check("done_pulse_width", done, 0);
    check("busy_falls_after_done", busy, 0);
    check("gap_enable_low", enable, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int dcnt;

    vecs[0]  = '{0, 0, 0, 18};
    vecs[1]  = '{0, 0, 5, 2};
    vecs[2]  = '{0, 0, 6, 2};
    vecs[3]  = '{0, 0, 9, 2};
    vecs[4]  = '{0, 0, 10, 2};
    vecs[5]  = '{0, 0, 15, 18};
    vecs[6]  = '{-3, -3, 0, 0};
    vecs[7]  = '{-3, -3, 1, 4};
    vecs[8]  = '{-3, -3, 4, 4};
    vecs[9]  = '{-3, -3, 15, 72};
    vecs[10] = '{-128, 127, 12, 31001};
    vecs[11] = '{-128, 127, 3, 34061};
    vecs[12] = '{-128, -128, 15, 34322};
    vecs[13] = '{127, 127, 0, 33800};

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    rx_i  = '0;
    rx_q  = '0;
    repeat (2) @(negedge clk);
    check("reset_enable", enable, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_node", node_out, 0);
    check("reset_ed", ed_out, 0);
    rst_n = 1'b1;

    // Table: one frame per vector, then the hand value for the listed node.
    for (int i = 0; i < 14; i++) begin
      launch(vecs[i].ri, vecs[i].rq, 1'b0);
      collect(vecs[i].ri, vecs[i].rq);
      check($sformatf("vec%0d_node%0d_ed", i, vecs[i].node), cap_ed[vecs[i].node], vecs[i].ed);
    end

    // Back-to-back: start held through a whole frame, accepted once busy drops.
    launch(1, -2, 1'b1);
    collect(1, -2);
    @(negedge clk);
    check("restart_when_idle", busy, 1);
    start = 1'b0;
    collect(1, -2);

    // abort together with start in IDLE: no frame.
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_beats_start_busy", busy, 0);
    @(negedge clk);
    check("abort_beats_start_busy_later", busy, 0);

    // abort on the 5th enable cycle.
    launch(0, 0, 1'b0);
    k = 0;
    while (!enable && k < 12) begin
      @(negedge clk);
      k++;
    end
    check("abort_frame_started", enable, 1);
    repeat (4) @(negedge clk);
    check("abort_at_fifth_pair", node_out, 4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_enable_low", enable, 0);
    check("abort_busy_low", busy, 0);
    check("abort_no_done", done, 0);
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || enable) dcnt++;
    end
    check("abort_quiet_after", dcnt, 0);
    launch(0, 0, 1'b0);
    collect(0, 0);

    // Reset mid-frame: outputs clear before any clock edge.
    launch(-3, -3, 1'b0);
    k = 0;
    while (!enable && k < 12) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check("pre_reset_enable", enable, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_enable", enable, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_done", done, 0);
    check("async_reset_node", node_out, 0);
    check("async_reset_ed", ed_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after_reset_idle", busy, 0);
    launch(-3, -3, 1'b0);
    collect(-3, -3);
    check("post_reset_node15_ed", cap_ed[15], 72);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
